// File: rtl/fpu_pkg.sv
// Shared single-precision constants and field types for the FPU datapath.
package fpu_pkg;

    localparam int unsigned EXP_BIAS         = 127;
    localparam int unsigned EXP_MAX          = 255;
    localparam int unsigned FRAC_W           = 23;
    localparam int unsigned FINV_LAT_DEFAULT = 2;
    localparam int unsigned RECIP_EXP_ADJ    = 126;

    typedef struct packed {
        logic              sign;
        logic [7:0]        exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef enum logic [1:0] {
        SpNone,
        SpInf,
        SpZero
    } special_e;

endpackage

// File: rtl/fdiv_align_delay.sv
// Shift register holding {valid, x} until the matching reciprocal word arrives.
module fdiv_align_delay #(
    parameter int unsigned Depth = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_in,
    input  logic [31:0] x,
    output logic        valid_dly,
    output logic [31:0] x_dly
);

    if (Depth == 0) begin : g_bypass
        assign valid_dly = valid_in;
        assign x_dly     = x;
    end else begin : g_shift
        logic [Depth-1:0] valid_q;
        logic [31:0]      x_q [Depth];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                valid_q <= '0;
                for (int i = 0; i < int'(Depth); i++) begin
                    x_q[i] <= '0;
                end
            end else begin
                valid_q[0] <= valid_in;
                x_q[0]     <= x;
                for (int i = 1; i < int'(Depth); i++) begin
                    valid_q[i] <= valid_q[i-1];
                    x_q[i]     <= x_q[i-1];
                end
            end
        end

        assign valid_dly = valid_q[Depth-1];
        assign x_dly     = x_q[Depth-1];
    end

endmodule

// File: rtl/fdiv_post.sv
// Divider back end: x * (2/y) with exponent fix-up, specials and truncating normalize.
// Define FDIV_FLAGS_EN to add the {dz, ovf, unf} flags output.
module fdiv_post
    import fpu_pkg::*;
#(
    parameter int unsigned FINV_LAT = FINV_LAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_in,
    input  logic [31:0] x,
    input  logic [31:0] y_inv,
    output logic [31:0] q,
    output logic        valid_out
`ifdef FDIV_FLAGS_EN
    ,
    output logic [2:0]  flags
`endif
);

    localparam logic signed [9:0] ExMax = 10'(EXP_MAX);
    localparam logic signed [9:0] ExAdj = 10'(RECIP_EXP_ADJ);

    // Stage A: align x with the reciprocal word
    logic        valid_a;
    logic [31:0] x_a;

    fdiv_align_delay #(
        .Depth(FINV_LAT)
    ) u_align (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (valid_in),
        .x        (x),
        .valid_dly(valid_a),
        .x_dly    (x_a)
    );

    // Stage M: sign, mantissa product, biased exponent, special class
    fp32_t              xa;
    fp32_t              yr;
    logic [47:0]        prod_full;
    logic signed [9:0]  ex_d;
    special_e           spec_d;

    logic               valid_m_q;
    logic               sign_m_q;
    logic [24:0]        prod_m_q;
    logic signed [9:0]  ex_m_q;
    special_e           spec_m_q;

    logic               unused_prod;

    assign xa          = x_a;
    assign yr          = y_inv;
    assign prod_full   = 48'({1'b1, xa.frac}) * 48'({1'b1, yr.frac});
    assign ex_d        = $signed({2'b00, xa.exp}) - $signed({2'b00, yr.exp}) + ExAdj;
    assign unused_prod = ^prod_full[22:0];

    always_comb begin
        spec_d = SpNone;
        if (yr.exp == 8'h00) begin
            spec_d = SpInf;
        end else if (xa.exp == 8'(EXP_MAX)) begin
            spec_d = SpInf;
        end else if (xa.exp == 8'h00) begin
            spec_d = SpZero;
        end else if (yr.exp == 8'(EXP_MAX)) begin
            spec_d = SpZero;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_m_q <= 1'b0;
            sign_m_q  <= 1'b0;
            prod_m_q  <= '0;
            ex_m_q    <= '0;
            spec_m_q  <= SpNone;
        end else begin
            valid_m_q <= valid_a;
            sign_m_q  <= xa.sign ^ yr.sign;
            prod_m_q  <= prod_full[47:23];
            ex_m_q    <= ex_d;
            spec_m_q  <= spec_d;
        end
    end

    // Stage N: normalize, saturate / flush, select result
    logic signed [9:0]   ex_n;
    logic [FRAC_W-1:0]   frac_n;
    logic                ovf_n;
    logic                unf_n;
    logic [31:0]         q_d;

    logic                valid_q;
    logic [31:0]         q_q;

    always_comb begin
        ex_n   = ex_m_q;
        frac_n = prod_m_q[22:0];
        ovf_n  = 1'b0;
        unf_n  = 1'b0;
        if (prod_m_q[24]) begin
            ex_n   = ex_m_q + 10'sd1;
            frac_n = prod_m_q[23:1];
        end
        case (spec_m_q)
            SpInf:   q_d = {sign_m_q, 8'hFF, 23'h0};
            SpZero:  q_d = {sign_m_q, 31'h0};
            default: begin
                if (ex_n >= ExMax) begin
                    q_d   = {sign_m_q, 8'hFF, 23'h0};
                    ovf_n = 1'b1;
                end else if (ex_n <= 10'sd0) begin
                    q_d   = {sign_m_q, 31'h0};
                    unf_n = 1'b1;
                end else begin
                    q_d = {sign_m_q, ex_n[7:0], frac_n};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            q_q     <= '0;
        end else begin
            valid_q <= valid_m_q;
            if (valid_m_q) begin
                q_q <= q_d;
            end
        end
    end

    assign q         = q_q;
    assign valid_out = valid_q;

`ifdef FDIV_FLAGS_EN
    logic       dz_m_q;
    logic [2:0] flags_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dz_m_q  <= 1'b0;
            flags_q <= '0;
        end else begin
            dz_m_q <= (yr.exp == 8'h00);
            if (valid_m_q) begin
                flags_q <= {dz_m_q, ovf_n, unf_n};
            end
        end
    end

    assign flags = flags_q;
`else
    logic unused_flags;
    assign unused_flags = ovf_n ^ unf_n;
`endif

endmodule

// File: tb/tb_fdiv_post.sv
// Randomized bench for fdiv_post against an arithmetic reference of the divide back end.
module tb_fdiv_post;

    localparam int unsigned Lat = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] x = '0;
    logic [31:0] y_inv = '0;
    logic [31:0] q;
    logic        valid_out;
`ifdef FDIV_FLAGS_EN
    logic [2:0]  flags;
`endif

    fdiv_post #(
        .FINV_LAT(Lat)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (valid_in),
        .x        (x),
        .y_inv    (y_inv),
        .q        (q),
        .valid_out(valid_out)
`ifdef FDIV_FLAGS_EN
        ,
        .flags    (flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] q;
        logic [2:0]  f;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] yh [Lat];
    logic [31:0] last_q = '0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        exp_v;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %08h, expected %08h (cycle %0d)", tag, got, want, cyc);
    endtask

    // Reference: real-valued reading of the rules, returns {dz, ovf, unf, q}
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b);
        int          ea = int'(a[30:23]);
        int          eb = int'(b[30:23]);
        logic        s = a[31] ^ b[31];
        longint      ma = longint'(a[22:0]) + (longint'(1) << 23);
        longint      mb = longint'(b[22:0]) + (longint'(1) << 23);
        longint      p;
        int          e;
        logic [22:0] fr;
        if (eb == 0)   return {3'b100, s, 8'hFF, 23'h0};
        if (ea == 255) return {3'b000, s, 8'hFF, 23'h0};
        if (ea == 0)   return {3'b000, s, 31'h0};
        if (eb == 255) return {3'b000, s, 31'h0};
        p = ma * mb;
        e = ea - eb + 126;
        if (p >= (longint'(1) << 47)) begin
            e  = e + 1;
            fr = 23'(p / (longint'(1) << 24));
        end else begin
            fr = 23'(p / (longint'(1) << 23));
        end
        if (e >= 255) return {3'b010, s, 8'hFF, 23'h0};
        if (e <= 0)   return {3'b001, s, 31'h0};
        return {3'b000, s, e[7:0], fr};
    endfunction

    task automatic step(input logic v, input logic [31:0] xv, input logic [31:0] yv,
                        input logic [34:0] e);
        exp_t t;
        @(posedge clk);
        #1;
        valid_in = v;
        x        = v ? xv : $urandom();
        y_inv    = yh[Lat-1];
        for (int i = Lat - 1; i > 0; i--) yh[i] = yh[i-1];
        yh[0] = v ? yv : $urandom();
        if (v) begin
            t.q   = e[31:0];
            t.f   = e[34:32];
            t.due = cyc + Lat + 2;
            exp_q.push_back(t);
        end
    endtask

    task automatic op(input logic [31:0] xv, input logic [31:0] yv);
        step(1'b1, xv, yv, model(xv, yv));
    endtask

    task automatic op_exp(input logic [31:0] xv, input logic [31:0] yv, input logic [34:0] e);
        step(1'b1, xv, yv, e);
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 35'h0);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0] ex;
        case ($urandom_range(0, 9))
            0:       ex = 8'd0;
            1:       ex = 8'd255;
            2:       ex = 8'd1;
            3:       ex = 8'd254;
            default: ex = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom_range(0, 1)), ex, 23'($urandom())};
    endfunction

    always @(negedge clk) begin
        if (rstn && mon_en) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            check("valid_out", {31'h0, valid_out}, {31'h0, exp_v});
            if (exp_v) begin
                exp_t e;
                e = exp_q.pop_front();
                check("q", q, e.q);
`ifdef FDIV_FLAGS_EN
                check("flags", {29'h0, flags}, {29'h0, e.f});
`endif
                last_q = e.q;
            end else begin
                check("q_hold", q, last_q);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < int'(Lat); i++) yh[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'h0, valid_out}, 32'h0);
        check("reset_q", q, 32'h0);
`ifdef FDIV_FLAGS_EN
        check("reset_flags", {29'h0, flags}, 32'h0);
`endif
        #1 rstn = 1'b1;
        mon_en = 1'b1;

        // Directed cases
        op_exp(32'h40C00000, 32'h402AAAAA, {3'b000, 32'h3FFFFFFF});
        idle();
        op_exp(32'h3F800000, 32'h3F000000, {3'b000, 32'h3F800000});
        op_exp(32'h40000000, 32'h80000000, {3'b100, 32'hFF800000});
        op_exp(32'h7F000000, 32'h00800000, {3'b010, 32'h7F800000});
        op_exp(32'h00800000, 32'h7F000000, {3'b001, 32'h00000000});
        repeat (6) idle();

        // Back-to-back burst, then one bubble, then one more
        op_exp(32'h3F800000, 32'h3F000000, {3'b000, 32'h3F800000});
        op(32'h40400000, 32'h3F2AAAAA);
        op(32'hC1200000, 32'h3F4CCCCC);
        op(32'h3FC00000, 32'hBF800000);
        op(32'h42C80000, 32'h3E23D70A);
        idle();
        op(32'h40A00000, 32'h3F000000);
        repeat (6) idle();

        // Randomized traffic with bubbles
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) op(rand_fp(), rand_fp());
            else idle();
        end
        repeat (6) idle();

        // Reset with operations in flight, one of them leaving the pipe right now
        op(32'h3F800000, 32'h3F000000);
        op(32'h40000000, 32'h3F000000);
        op(32'h40400000, 32'h3F000000);
        op(32'h40800000, 32'h3F000000);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("pre_rst_valid", {31'h0, valid_out}, 32'h1);
        #1 rstn = 1'b0;
        #1;
        check("rst_valid", {31'h0, valid_out}, 32'h0);
        check("rst_q", q, 32'h0);
`ifdef FDIV_FLAGS_EN
        check("rst_flags", {29'h0, flags}, 32'h0);
`endif
        exp_q.delete();
        last_q = '0;
        for (int i = 0; i < int'(Lat); i++) yh[i] = '0;
        #1 rstn = 1'b1;
        repeat (2) idle();
        op_exp(32'h40C00000, 32'h402AAAAA, {3'b000, 32'h3FFFFFFF});
        repeat (8) idle();

        check("drain", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
